uart_tx_fifo: RTL
=================

Name: uart_tx_fifo

Overview:
- Parametrised transmit buffer between the CPU write port and the UART transmitter.
- Successor to the fixed 4-entry, edge-triggered transmit buffer: configurable width and depth, and fully synchronous (single clock, sampled strobes).
- Two modes: BATCH (fill completely, then drain completely; the legacy behaviour, generalised) and STREAM (ordinary FIFO).
- Adds empty/count status, sticky overflow/underflow flags and a transmitter-ready signal.

Parameters:
- DATA_W, 8, width of each buffered word
- DEPTH, 4, number of entries; any value >= 2; need not be a power of two
- MODE, 0, 0 = BATCH, 1 = STREAM; values from the shared package constants

Ports:
- clk  in  1  system clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high reset
- wr  in  1  write strobe, level-sampled; each high cycle requests one push
- w_data  in  DATA_W  write data, sampled with wr
- rd  in  1  read strobe from the transmitter, level-sampled; each high cycle requests one pop
- r_data  out  DATA_W  head word (show-ahead), combinational from storage
- full  out  1  writes are currently not accepted
- empty  out  1  no entries are stored
- count  out  $clog2(DEPTH+1)  current number of stored entries
- tx_ready  out  1  transmitter may pop
- overflow  out  1  sticky; set when a write is rejected
- underflow  out  1  sticky; set when a read is rejected
- clr_err  in  1  clears overflow and underflow on the next edge

Behaviour:
- Reset (synchronous, active-high):
  - wr_ptr, rd_ptr and count go to 0; the state machine goes to FILL.
  - overflow and underflow go to 0.
  - Storage contents are not cleared.
  - Outputs after reset: empty=1, full=0, tx_ready=0, count=0, r_data=0.
  - Reset overrides every simultaneous wr, rd or clr_err.
- Read data: r_data = storage[rd_ptr] when not empty, otherwise all zeros. There is no read latency; the head word is valid in the same cycle tx_ready is high.
- Pointers:
  - Each pointer increments modulo DEPTH. It wraps to 0 after DEPTH-1 by explicit compare, not natural overflow.
  - count increments on an accepted push and decrements on an accepted pop. It is unchanged when both occur in the same cycle.
- STREAM mode (MODE = 1):
  - Push accepted when wr is high and (count < DEPTH, or a pop is accepted in the same cycle).
  - Pop accepted when rd is high and count > 0.
  - Simultaneous wr and rd when empty: the push is accepted, the pop is rejected and underflow is set.
  - Simultaneous wr and rd when full: both are accepted and count stays at DEPTH.
  - full = (count == DEPTH); tx_ready = ~empty.
- BATCH mode (MODE = 0) uses a two-state machine:
  - FILL:
    - Pushes are accepted while count < DEPTH.
    - rd is rejected and sets underflow.
    - The cycle in which the push makes count equal DEPTH, the state moves to DRAIN on the next edge.
    - full = 0, tx_ready = 0.
  - DRAIN:
    - full = 1, tx_ready = 1.
    - Every wr is rejected and sets overflow.
    - Each rd pops one entry.
    - On the pop that makes count 0, the state returns to FILL and both pointers are forced to 0.
  - A simultaneous wr in the same cycle as the last pop is rejected and sets overflow.
- Error flags:
  - A rejected push sets overflow; a rejected pop sets underflow.
  - If clr_err and a new error occur in the same cycle, the flag ends up set (set wins over clear).
- Reset mid-batch discards all pending data; the next batch starts at entry 0.

Decomposition:
- Shared package uart_pkg holds:
  - MODE_BATCH = 0, MODE_STREAM = 1
  - the state encoding {FILL, DRAIN}
  - DATA_W_DEFAULT = 8
- One sub-module, fifo_ram: DEPTH x DATA_W storage with a synchronous write port and an asynchronous read port. It has no reset.
- Pointer, count and state-machine logic stay in uart_tx_fifo.

Test Plan:
- BATCH, DEPTH=4: reset, then push 0x41, 0x42, 0x43, 0x44 -> full=1 and tx_ready=1 the cycle after the 4th push, r_data=0x41. Four single-cycle rd pulses -> r_data goes 0x42, 0x43, 0x44, then 0; empty=1, full=0, state back in FILL.
- BATCH: push a 5th word while in DRAIN -> rejected, overflow=1, count stays 4. clr_err -> overflow=0. rd while in FILL with count=2 -> underflow=1, count stays 2.
- STREAM, DEPTH=3: push 0x10, 0x11, 0x12 -> full=1. wr=0x13 together with rd -> count stays 3, r_data goes 0x11, and wr_ptr wraps to 0 (0x13 stored in entry 0).
- STREAM: with empty=1, assert wr=0x55 and rd together -> count=1, r_data=0x55, underflow=1.
- Reset asserted mid-DRAIN with count=2 -> next edge: count=0, empty=1, tx_ready=0, flags 0. A following push of 0xAA is stored in entry 0 and appears on r_data.
- Parameter sweep DATA_W=16, DEPTH=5 in both modes: random wr/rd stimulus checked against a scoreboard queue model for ordering, count, full/empty and flag behaviour.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the UART transmit buffer family.
// Mode selectors are compared against the top-level MODE parameter.
package uart_pkg;

   localparam int MODE_BATCH     = 0;
   localparam int MODE_STREAM    = 1;
   localparam int DATA_W_DEFAULT = 8;

   typedef enum logic {
      FILL  = 1'b0,
      DRAIN = 1'b1
   } tx_state_t;

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x DATA_W storage: synchronous write port, asynchronous read port.
// Holds no control state; pointers and occupancy live in the owner.
module fifo_ram #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] w_addr,
   input  logic [DATA_W-1:0] w_data,
   input  logic [ADDR_W-1:0] r_addr,
   output logic [DATA_W-1:0] r_data
);

   logic [DATA_W-1:0] mem [DEPTH];

   // NOTE: storage is deliberately not reset; occupancy is tracked by the
   // pointers and count, so clearing the array would only cost a wide reset net.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[w_addr] <= w_data;
      end
   end

   assign r_data = mem[r_addr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit buffer between the CPU write port and the UART transmitter.
// BATCH mode fills completely then drains completely; STREAM mode is a plain FIFO.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEFAULT,
   parameter int DEPTH  = 4,
   parameter int MODE   = MODE_BATCH
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       wr,
   input  logic [DATA_W-1:0]          w_data,
   input  logic                       rd,
   output logic [DATA_W-1:0]          r_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       tx_ready,
   output logic                       overflow,
   output logic                       underflow,
   input  logic                       clr_err
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);
   localparam logic [CW-1:0] COUNT_LAST = CW'(DEPTH - 1);
   localparam logic [PW-1:0] PTR_LAST   = PW'(DEPTH - 1);

   tx_state_t         state, state_nxt;
   logic [PW-1:0]     wr_ptr, rd_ptr;
   logic              push_ok, pop_ok;
   logic              ovf_set, udf_set;
   logic              ptr_clear;
   logic [DATA_W-1:0] ram_r_data;

   // Explicit wrap so non-power-of-two depths stay in range.
   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] ptr);
      return (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
   endfunction

   fifo_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (PW)
   ) u_ram (
      .clk    (clk),
      .we     (push_ok),
      .w_addr (wr_ptr),
      .w_data (w_data),
      .r_addr (rd_ptr),
      .r_data (ram_r_data)
   );

   // NOTE: every signal gets a default before any branch, so no path through
   // this block can leave one unassigned and infer a latch.
   always_comb begin
      push_ok   = 1'b0;
      pop_ok    = 1'b0;
      full      = 1'b0;
      tx_ready  = 1'b0;
      ptr_clear = 1'b0;
      state_nxt = state;
      if (MODE == MODE_STREAM) begin
         // A pop in the same cycle frees the slot, so a full FIFO still takes the write.
         pop_ok   = rd && (count != '0);
         push_ok  = wr && ((count != COUNT_FULL) || pop_ok);
         full     = (count == COUNT_FULL);
         tx_ready = (count != '0);
      end else begin
         unique case (state)
            FILL: begin
               push_ok = wr && (count != COUNT_FULL);
               if (push_ok && (count == COUNT_LAST)) begin
                  state_nxt = DRAIN;
               end
            end
            DRAIN: begin
               full     = 1'b1;
               tx_ready = 1'b1;
               pop_ok   = rd && (count != '0);
               if (pop_ok && (count == CW'(1))) begin
                  state_nxt = FILL;
                  ptr_clear = 1'b1;
               end
            end
            default: state_nxt = FILL;
         endcase
      end
      ovf_set = wr && !push_ok;
      udf_set = rd && !pop_ok;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= FILL;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         state <= state_nxt;
         if (ptr_clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (push_ok) wr_ptr <= ptr_next(wr_ptr);
            if (pop_ok)  rd_ptr <= ptr_next(rd_ptr);
         end
         if (push_ok && !pop_ok) begin
            count <= count + 1'b1;
         end else if (pop_ok && !push_ok) begin
            count <= count - 1'b1;
         end
         // A new error in the clearing cycle keeps the flag set.
         overflow  <= ovf_set || (overflow  && !clr_err);
         underflow <= udf_set || (underflow && !clr_err);
      end
   end

   assign empty  = (count == '0);
   assign r_data = empty ? '0 : ram_r_data;

endmodule
